// File: rtl/tis_pkg.sv
// Shared types and helpers for the TIS edge port: word format, value range, and saturation.
package tis_pkg;

    localparam int WORD_W  = 11;
    localparam int LVL_W   = 5;
    localparam int TIS_MAX = 999;
    localparam int TIS_MIN = -999;

    typedef logic signed [WORD_W-1:0] tis_word_t;

    function automatic tis_word_t clamp(input tis_word_t v);
        if (v > tis_word_t'(TIS_MAX)) begin
            return tis_word_t'(TIS_MAX);
        end else if (v < tis_word_t'(TIS_MIN)) begin
            return tis_word_t'(TIS_MIN);
        end
        return v;
    endfunction

endpackage

// File: rtl/tis_fifo.sv
// Registered-output FIFO of tis words with explicit occupancy; head reads as zero when empty.
module tis_fifo
    import tis_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  tis_word_t        wdata,
    input  logic             pop,
    output tis_word_t        rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tis_word_t        mem_q [DEPTH];
    tis_word_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/tis_edge_port.sv
// Host/core boundary port: clamped ingress FIFO toward the core lane, raw egress FIFO back to host.
module tis_edge_port
    import tis_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_in_valid,
    input  tis_word_t        host_in_data,
    output logic             host_in_ready,
    output logic             host_out_valid,
    output tis_word_t        host_out_data,
    input  logic             host_out_ready,
    output logic             rready,
    output tis_word_t        data,
    input  logic             read,
    output logic             wready,
    input  logic             write,
    input  tis_word_t        wdata,
    output logic [LVL_W-1:0] in_level,
    output logic [LVL_W-1:0] out_level,
    output logic             proto_err
);

    logic in_full, in_empty, out_full, out_empty;
    logic proto_err_q, proto_err_d;

    // Readies are gated by reset so they stay low while held and rise as soon as it releases.
    assign host_in_ready  = rst & ~in_full;
    assign wready         = rst & ~out_full;
    assign rready         = ~in_empty;
    assign host_out_valid = ~out_empty;
    assign proto_err      = proto_err_q;

    tis_fifo #(
        .DEPTH(DEPTH)
    ) u_ingress (
        .clk   (clk),
        .rst   (rst),
        .push  (host_in_valid & host_in_ready),
        .wdata (clamp(host_in_data)),
        .pop   (read & rready),
        .rdata (data),
        .full  (in_full),
        .empty (in_empty),
        .level (in_level)
    );

    tis_fifo #(
        .DEPTH(DEPTH)
    ) u_egress (
        .clk   (clk),
        .rst   (rst),
        .push  (write & wready),
        .wdata (wdata),
        .pop   (host_out_ready & host_out_valid),
        .rdata (host_out_data),
        .full  (out_full),
        .empty (out_empty),
        .level (out_level)
    );

    always_comb begin
        proto_err_d = proto_err_q | (read & ~rready) | (write & ~wready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

endmodule
